// File: rtl/mbox_slave.sv
// Four-FIFO inter-core mailbox on one xbar slave port, with per-FIFO non-empty interrupts.
// Accesses complete on the request edge; read data comes back one cycle later; the port never stalls.
module mbox_slave #(
    parameter int DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [31:0] bus_addr,
    input  logic [3:0]  bus_be,
    input  logic [31:0] bus_wdata,
    output logic        bus_ack,
    output logic        bus_resp,
    output logic [31:0] bus_rdata,
    output logic [3:0]  irq_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   mem_q [4][DEPTH];
    logic [PW-1:0] wr_ptr_q [4];
    logic [PW-1:0] wr_ptr_d [4];
    logic [PW-1:0] rd_ptr_q [4];
    logic [PW-1:0] rd_ptr_d [4];
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [3:0]    unf_q, unf_d, ovf_q, ovf_d, mask_q, mask_d, irq_q, irq_d;
    logic [3:0]    full, empty;
    logic          resp_q, resp_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          mem_we;
    logic [3:0]    idx;
    logic [1:0]    n;
    logic          unused_addr_bits;

    assign idx              = bus_addr[5:2];
    assign n                = idx[1:0];
    assign unused_addr_bits = ^{bus_addr[31:6], bus_addr[1:0]};
    assign bus_ack          = bus_req;
    assign bus_resp         = resp_q;
    assign bus_rdata        = rdata_q;
    assign irq_o            = irq_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            full[i]  = (cnt_q[i] == CW'(DEPTH));
            empty[i] = (cnt_q[i] == '0);
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        unf_d    = unf_q;
        ovf_d    = ovf_q;
        mask_d   = mask_q;
        rdata_d  = rdata_q;
        resp_d   = 1'b0;
        mem_we   = 1'b0;
        irq_d    = '0;

        if (bus_req && bus_we) begin
            if (idx < 4'd4) begin
                if (bus_be == 4'hF) begin
                    if (full[n]) begin
                        ovf_d[n] = 1'b1;
                    end else begin
                        mem_we      = 1'b1;
                        wr_ptr_d[n] = wr_ptr_q[n] + PW'(1);
                        cnt_d[n]    = cnt_q[n] + CW'(1);
                    end
                end
            end else if (idx < 4'd8) begin
                if (bus_wdata[3]) unf_d[n] = 1'b0;
                if (bus_wdata[2]) ovf_d[n] = 1'b0;
            end else if (idx == 4'd8) begin
                mask_d = bus_wdata[3:0];
            end
        end else if (bus_req) begin
            resp_d  = 1'b1;
            rdata_d = '0;
            if (idx < 4'd4) begin
                // An empty pop leaves the pointers alone and only records the underflow.
                if (empty[n]) begin
                    unf_d[n] = 1'b1;
                end else begin
                    rdata_d     = mem_q[n][rd_ptr_q[n]];
                    rd_ptr_d[n] = rd_ptr_q[n] + PW'(1);
                    cnt_d[n]    = cnt_q[n] - CW'(1);
                end
            end else if (idx < 4'd8) begin
                rdata_d = {{(16-CW){1'b0}}, cnt_q[n], 12'b0, unf_q[n], ovf_q[n], full[n], empty[n]};
            end else if (idx == 4'd8) begin
                rdata_d = {28'b0, mask_q};
            end
        end

        for (int i = 0; i < 4; i++) begin
            irq_d[i] = mask_d[i] & (cnt_d[i] != '0);
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            unf_q   <= '0;
            ovf_q   <= '0;
            mask_q  <= '0;
            irq_q   <= '0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            unf_q    <= unf_d;
            ovf_q    <= ovf_d;
            mask_q   <= mask_d;
            irq_q    <= irq_d;
            resp_q   <= resp_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage needs no reset: the counts alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[n][wr_ptr_q[n]] <= bus_wdata;
        end
    end

endmodule

// File: tb/tb_mbox_slave.sv
// Bench for mbox_slave: hand vectors, multi-cycle sequences and random traffic against a queue model.
module tb_mbox_slave;
    localparam int DEPTH = 8;

    logic        clk_i = 1'b0;
    logic        arst_i;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack, bus_resp;
    logic [31:0] bus_rdata;
    logic [3:0]  irq_o;

    mbox_slave #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .arst_i(arst_i), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_resp(bus_resp), .bus_rdata(bus_rdata), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one queue per mailbox plus flag bits.
    logic [31:0] mq [4][$];
    bit   [3:0]  m_unf, m_ovf, m_mask;

    typedef struct {
        logic        we;
        logic [3:0]  idx;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_unf = '0; m_ovf = '0; m_mask = '0;
    endtask

    task automatic model_acc(input logic we, input logic [3:0] idx, input logic [3:0] be,
                             input logic [31:0] wd, output logic [31:0] rd);
        int k;
        k  = int'(idx[1:0]);
        rd = '0;
        if (we) begin
            if (idx < 4) begin
                if (be == 4'hF) begin
                    if (mq[k].size() == DEPTH) m_ovf[k] = 1'b1;
                    else mq[k].push_back(wd);
                end
            end else if (idx < 8) begin
                if (wd[3]) m_unf[k] = 1'b0;
                if (wd[2]) m_ovf[k] = 1'b0;
            end else if (idx == 8) begin
                m_mask = wd[3:0];
            end
        end else begin
            if (idx < 4) begin
                if (mq[k].size() == 0) m_unf[k] = 1'b1;
                else rd = mq[k].pop_front();
            end else if (idx < 8) begin
                rd = (mq[k].size() << 16) | (m_unf[k] << 3) | (m_ovf[k] << 2)
                   | ((mq[k].size() == DEPTH) << 1) | (mq[k].size() == 0);
            end else if (idx == 8) begin
                rd = {28'b0, m_mask};
            end
        end
    endtask

    function automatic logic [3:0] model_irq();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = m_mask[i] && (mq[i].size() != 0);
        return r;
    endfunction

    // One bus access per cycle; compares resp, read data and irq against the model.
    task automatic acc(input logic we, input logic [3:0] idx, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] rd);
        logic [31:0] exp;
        @(negedge clk_i);
        bus_req   = 1'b1;
        bus_we    = we;
        bus_addr  = {26'($urandom), idx, 2'($urandom)};
        bus_be    = be;
        bus_wdata = wd;
        model_acc(we, idx, be, wd, exp);
        @(posedge clk_i);
        #1;
        bus_req = 1'b0;
        check("resp", 32'(bus_resp), 32'(!we));
        if (!we) check("rdata", bus_rdata, exp);
        check("irq", 32'(irq_o), 32'(model_irq()));
        rd = bus_rdata;
    endtask

    task automatic acc_exp(input string nm, input logic we, input logic [3:0] idx,
                           input logic [3:0] be, input logic [31:0] wd, input logic [31:0] exp);
        logic [31:0] rd;
        acc(we, idx, be, wd, rd);
        if (!we) check(nm, rd, exp);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] rd;
        logic [31:0] v;
        logic [3:0]  ridx, rbe;
        logic        rwe;

        arst_i = 1'b1; bus_req = 1'b0; bus_we = 1'b0;
        bus_addr = '0; bus_be = '0; bus_wdata = '0;
        model_reset();
        #1;
        check("rst_resp", 32'(bus_resp), 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        check("rst_rdata", bus_rdata, 32'h0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        arst_i = 1'b0;
        bus_req = 1'b1;
        #1;
        check("ack", 32'(bus_ack), 32'h1);
        bus_req = 1'b0;
        #1;
        check("ack_low", 32'(bus_ack), 32'h0);

        vecs = '{
            '{1'b0, 4'd4,  4'hF, 32'h0,         32'h0000_0001},
            '{1'b1, 4'd1,  4'hF, 32'hA5A5_0001, 32'h0},
            '{1'b0, 4'd1,  4'hF, 32'h0,         32'hA5A5_0001},
            '{1'b0, 4'd5,  4'hF, 32'h0,         32'h0000_0001},
            '{1'b0, 4'd0,  4'hF, 32'h0,         32'h0},
            '{1'b0, 4'd4,  4'hF, 32'h0,         32'h0000_0009},
            '{1'b1, 4'd4,  4'hF, 32'h8,         32'h0},
            '{1'b0, 4'd4,  4'hF, 32'h0,         32'h0000_0001},
            '{1'b1, 4'd0,  4'h3, 32'h1234_5678, 32'h0},
            '{1'b0, 4'd4,  4'hF, 32'h0,         32'h0000_0001},
            '{1'b0, 4'd0,  4'hF, 32'h0,         32'h0},
            '{1'b0, 4'd4,  4'hF, 32'h0,         32'h0000_0009},
            '{1'b0, 4'd12, 4'hF, 32'h0,         32'h0},
            '{1'b1, 4'd12, 4'hF, 32'hFFFF_FFFF, 32'h0},
            '{1'b1, 4'd4,  4'hF, 32'hC,         32'h0},
            '{1'b0, 4'd8,  4'hF, 32'h0,         32'h0}
        };
        foreach (vecs[i])
            acc_exp($sformatf("vec%0d", i), vecs[i].we, vecs[i].idx, vecs[i].be, vecs[i].wd, vecs[i].exp);

        // Fill, overflow and drain one mailbox with interrupts enabled.
        acc_exp("mask_wr", 1'b1, 4'd8, 4'hF, 32'hFFFF_FFFF, 32'h0);
        acc_exp("mask_rd", 1'b0, 4'd8, 4'hF, 32'h0, 32'h0000_000F);
        for (int i = 0; i < DEPTH; i++) acc_exp("fill", 1'b1, 4'd2, 4'hF, 32'(i), 32'h0);
        check("irq2_full", 32'(irq_o[2]), 32'h1);
        acc_exp("stat2_full", 1'b0, 4'd6, 4'hF, 32'h0, (DEPTH << 16) | 2);
        acc_exp("ovf_push", 1'b1, 4'd2, 4'hF, 32'hDEAD, 32'h0);
        acc_exp("stat2_ovf", 1'b0, 4'd6, 4'hF, 32'h0, (DEPTH << 16) | 6);
        for (int i = 0; i < DEPTH; i++) acc_exp("drain", 1'b0, 4'd2, 4'hF, 32'h0, 32'(i));
        check("irq2_drained", 32'(irq_o[2]), 32'h0);
        acc_exp("clr_ovf", 1'b1, 4'd6, 4'hF, 32'h4, 32'h0);
        acc_exp("stat2_clr", 1'b0, 4'd6, 4'hF, 32'h0, 32'h0000_0001);

        // Interleaved push/pop walks the pointers around the ring several times.
        for (int i = 0; i < 3 * DEPTH; i++) begin
            v = 32'h3000_0000 + 32'(i * 7);
            acc_exp("wrap_push", 1'b1, 4'd3, 4'hF, v, 32'h0);
            check("wrap_irq", 32'(irq_o[3]), 32'h1);
            acc_exp("wrap_pop", 1'b0, 4'd3, 4'hF, 32'h0, v);
        end
        acc_exp("stat3_wrap", 1'b0, 4'd7, 4'hF, 32'h0, 32'h0000_0001);

        for (int i = 0; i < 600; i++) begin
            rwe  = ($urandom_range(0, 9) < 5);
            ridx = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            rbe  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            acc(rwe, ridx, rbe, $urandom, rd);
        end

        // Reset arriving while a read response is on the bus.
        acc_exp("pre_rst_push", 1'b1, 4'd1, 4'hF, 32'h1234_ABCD, 32'h0);
        while (mq[1].size() > 1) acc(1'b0, 4'd1, 4'hF, 32'h0, rd);
        v = mq[1][0];
        acc_exp("pre_rst_pop", 1'b0, 4'd1, 4'hF, 32'h0, v);
        #2;
        arst_i = 1'b1;
        #1;
        check("rst_mid_resp", 32'(bus_resp), 32'h0);
        check("rst_mid_rdata", bus_rdata, 32'h0);
        check("rst_mid_irq", 32'(irq_o), 32'h0);
        @(posedge clk_i);
        #1;
        check("rst_hold_resp", 32'(bus_resp), 32'h0);
        @(negedge clk_i);
        arst_i = 1'b0;
        model_reset();
        acc_exp("post_rst_stat1", 1'b0, 4'd5, 4'hF, 32'h0, 32'h0000_0001);
        acc_exp("post_rst_mask", 1'b0, 4'd8, 4'hF, 32'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
